// File: rtl/register_file.sv
// register_file: parametrised multi-port register file with byte-strobed writes,
// combinational read ports, optional same-cycle write bypass, optional hardwired
// zero register and a per-register pending scoreboard for issue stalls.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-high reset (clears data and pending bits)
//   i_write_enable   write request this cycle
//   i_write_addr     destination register
//   i_write_data     write data
//   i_write_strobe   byte-lane enables, bit k covers bits [8k+7:8k]
//   i_reserve_enable mark a register pending (producer issued)
//   i_reserve_addr   register to mark pending
//   i_read_addr      port p address at [p*ADDR_W +: ADDR_W]
//   o_read_data      port p data at [p*DATA_WIDTH +: DATA_WIDTH]
//   o_read_pending   pending flag of each port's addressed register
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REG    = 32,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned ADDR_W     = $clog2(NUM_REG)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_write_enable,
    input  logic [ADDR_W-1:0]              i_write_addr,
    input  logic [DATA_WIDTH-1:0]          i_write_data,
    input  logic [DATA_WIDTH/8-1:0]        i_write_strobe,
    input  logic                           i_reserve_enable,
    input  logic [ADDR_W-1:0]              i_reserve_addr,
    input  logic [NUM_READ*ADDR_W-1:0]     i_read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] o_read_data,
    output logic [NUM_READ-1:0]            o_read_pending
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    // NUM_REG needs one extra bit when it is an exact power of two.
    localparam logic [ADDR_W:0] NUM_REG_W = (ADDR_W + 1)'(NUM_REG);
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYPASS = (BYPASS != 0);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [NUM_REG];
    logic [NUM_REG-1:0]    r_pending;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic w_write_valid;
    logic w_reserve_valid;

    assign w_write_valid = i_write_enable
                         && ({1'b0, i_write_addr} < NUM_REG_W)
                         && !(HAS_ZERO && (i_write_addr == '0));

    assign w_reserve_valid = i_reserve_enable
                           && ({1'b0, i_reserve_addr} < NUM_REG_W)
                           && !(HAS_ZERO && (i_reserve_addr == '0));

    // Byte strobes expanded to a bit mask, shared by the write path and bypass.
    logic [DATA_WIDTH-1:0] w_strobe_mask;

    always_comb begin
        w_strobe_mask = '0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            w_strobe_mask[8*k +: 8] = {8{i_write_strobe[k]}};
        end
    end

    // ------------------------------------------------------------------
    // Write decode and pending next-state
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] w_lane_we [NUM_REG];
    logic [NUM_REG-1:0]   w_pending_next;

    always_comb begin
        w_pending_next = r_pending;
        for (int i = 0; i < int'(NUM_REG); i++) begin
            w_lane_we[i] = '0;
            if (w_write_valid && (i_write_addr == ADDR_W'(i))) begin
                w_lane_we[i]      = i_write_strobe;
                // Cleared even for an all-zero strobe: the producer has retired.
                w_pending_next[i] = 1'b0;
            end
        end
        // Applied after the clear so a same-cycle reserve of the written
        // register leaves the bit set: the new producer supersedes the old one.
        for (int i = 0; i < int'(NUM_REG); i++) begin
            if (w_reserve_valid && (i_reserve_addr == ADDR_W'(i))) begin
                w_pending_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REG); i++) begin
                r_mem[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REG); i++) begin
                for (int k = 0; k < int'(NUM_LANES); k++) begin
                    if (w_lane_we[i][k]) begin
                        r_mem[i][8*k +: 8] <= i_write_data[8*k +: 8];
                    end
                end
            end
            r_pending <= w_pending_next;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_read
        logic [ADDR_W-1:0]     w_addr;
        logic [DATA_WIDTH-1:0] w_stored;
        logic                  w_stored_pend;
        logic                  w_addr_ok;
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] w_merged;

        assign w_addr = i_read_addr[p*ADDR_W +: ADDR_W];

        // Mux by comparison so out-of-range addresses simply select nothing.
        always_comb begin
            w_stored      = '0;
            w_stored_pend = 1'b0;
            for (int i = 0; i < int'(NUM_REG); i++) begin
                if (w_addr == ADDR_W'(i)) begin
                    w_stored      = r_mem[i];
                    w_stored_pend = r_pending[i];
                end
            end
        end

        assign w_addr_ok = ({1'b0, w_addr} < NUM_REG_W) && !(HAS_ZERO && (w_addr == '0));

        // A valid write already excludes the zero register and out-of-range targets.
        assign w_hit = HAS_BYPASS && w_write_valid && (i_write_addr == w_addr);

        assign w_merged = w_hit ? ((w_stored & ~w_strobe_mask) | (i_write_data & w_strobe_mask))
                                : w_stored;

        assign o_read_data[p*DATA_WIDTH +: DATA_WIDTH] = w_addr_ok ? w_merged : '0;

        // Data for a forwarded write is already valid, so it no longer stalls.
        assign o_read_pending[p] = w_addr_ok && w_stored_pend && !w_hit;
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: drives two register_file instances from shared stimulus.
//   dut_a: defaults (32 regs, zero register, bypass on)
//   dut_b: 24 regs, no zero register, bypass off
// A directed vector table covers the documented corner cases, then random
// traffic is compared against a per-instance behavioural model.
module tb_register_file;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        re;
    logic [4:0]  ra;
    logic [9:0]  rd_addr;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rpend_a, rpend_b;

    always #5 clk = ~clk;

    register_file dut_a (
        .clk              (clk),
        .rst              (rst),
        .i_write_enable   (we),
        .i_write_addr     (wa),
        .i_write_data     (wd),
        .i_write_strobe   (ws),
        .i_reserve_enable (re),
        .i_reserve_addr   (ra),
        .i_read_addr      (rd_addr),
        .o_read_data      (rdata_a),
        .o_read_pending   (rpend_a)
    );

    register_file #(
        .NUM_REG  (24),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) dut_b (
        .clk              (clk),
        .rst              (rst),
        .i_write_enable   (we),
        .i_write_addr     (wa),
        .i_write_data     (wd),
        .i_write_strobe   (ws),
        .i_reserve_enable (re),
        .i_reserve_addr   (ra),
        .i_read_addr      (rd_addr),
        .o_read_data      (rdata_b),
        .o_read_pending   (rpend_b)
    );

    // ---------------- behavioural model ----------------
    int          nreg [2] = '{32, 24};
    bit          zr   [2] = '{1'b1, 1'b0};
    bit          byp  [2] = '{1'b1, 1'b0};
    logic [31:0] m_data [2][32];
    bit          m_pend [2][32];

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] lane_mask(logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'hFF << (8 * k));
        return m;
    endfunction

    function automatic bit addr_ok(int c, int a);
        return (a < nreg[c]) && !(zr[c] && a == 0);
    endfunction

    function automatic bit fwd(int c, int a);
        return byp[c] && we && addr_ok(c, int'(wa)) && int'(wa) == a;
    endfunction

    function automatic logic [31:0] exp_data(int c, int a);
        logic [31:0] v;
        if (!addr_ok(c, a)) return 32'h0;
        v = m_data[c][a];
        if (fwd(c, a)) v = (v & ~lane_mask(ws)) | (wd & lane_mask(ws));
        return v;
    endfunction

    function automatic bit exp_pend(int c, int a);
        if (!addr_ok(c, a)) return 1'b0;
        if (fwd(c, a)) return 1'b0;
        return m_pend[c][a];
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_data[c][i] = 32'h0;
                    m_pend[c][i] = 1'b0;
                end
            end else begin
                if (we && addr_ok(c, int'(wa))) begin
                    m_data[c][wa] = (m_data[c][wa] & ~lane_mask(ws)) | (wd & lane_mask(ws));
                    m_pend[c][wa] = 1'b0;
                end
                if (re && addr_ok(c, int'(ra))) m_pend[c][ra] = 1'b1;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [63:0] d;
        logic [1:0]  pd;
        int          a;
        for (int c = 0; c < 2; c++) begin
            d  = (c == 0) ? rdata_a : rdata_b;
            pd = (c == 0) ? rpend_a : rpend_b;
            for (int p = 0; p < 2; p++) begin
                a = int'(rd_addr[p*AW +: AW]);
                check($sformatf("model_data dut%0d port%0d addr%0d", c, p, a),
                      d[p*32 +: 32], exp_data(c, a));
                check($sformatf("model_pend dut%0d port%0d addr%0d", c, p, a),
                      {31'h0, pd[p]}, {31'h0, exp_pend(c, a)});
            end
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        bit          re;
        logic [4:0]  ra;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] ea;   // dut_a port0 data
        logic [31:0] eb;   // dut_b port0 data
        bit          pa;   // dut_a port0 pending
        bit          pb;   // dut_b port0 pending
    } vec_t;

    vec_t tbl [23];

    initial begin
        tbl[0]  = '{0, 1, 5'd5,  32'hDEADBEEF, 4'hF, 0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'h0,        0, 0};
        tbl[1]  = '{1, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        tbl[2]  = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd5,  5'd5,  32'h0,        32'h0,        0, 0};
        tbl[3]  = '{0, 1, 5'd3,  32'h11223344, 4'hF, 0, 5'd0, 5'd3,  5'd3,  32'h11223344, 32'h0,        0, 0};
        tbl[4]  = '{0, 1, 5'd3,  32'hAABBCCDD, 4'h5, 0, 5'd0, 5'd3,  5'd3,  32'h11BB33DD, 32'h11223344, 0, 0};
        tbl[5]  = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd3,  5'd3,  32'h11BB33DD, 32'h11BB33DD, 0, 0};
        tbl[6]  = '{0, 1, 5'd0,  32'hFFFFFFFF, 4'hF, 1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        0, 0};
        tbl[7]  = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd0,  5'd0,  32'h0,        32'hFFFFFFFF, 0, 1};
        tbl[8]  = '{0, 1, 5'd30, 32'h55555555, 4'hF, 0, 5'd0, 5'd30, 5'd30, 32'h55555555, 32'h0,        0, 0};
        tbl[9]  = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd30, 5'd30, 32'h55555555, 32'h0,        0, 0};
        tbl[10] = '{0, 1, 5'd7,  32'h12345678, 4'hF, 0, 5'd0, 5'd7,  5'd7,  32'h12345678, 32'h0,        0, 0};
        tbl[11] = '{0, 1, 5'd7,  32'hCAFEF00D, 4'h3, 0, 5'd0, 5'd7,  5'd7,  32'h1234F00D, 32'h12345678, 0, 0};
        tbl[12] = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd7,  5'd7,  32'h1234F00D, 32'h1234F00D, 0, 0};
        tbl[13] = '{0, 0, 5'd0,  32'h0,        4'h0, 1, 5'd9, 5'd9,  5'd9,  32'h0,        32'h0,        0, 0};
        tbl[14] = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd9,  5'd9,  32'h0,        32'h0,        1, 1};
        tbl[15] = '{0, 1, 5'd9,  32'h00000099, 4'hF, 0, 5'd0, 5'd9,  5'd9,  32'h00000099, 32'h0,        0, 1};
        tbl[16] = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd9,  5'd9,  32'h00000099, 32'h00000099, 0, 0};
        tbl[17] = '{0, 1, 5'd9,  32'h0000AAAA, 4'hF, 1, 5'd9, 5'd9,  5'd9,  32'h0000AAAA, 32'h00000099, 0, 0};
        tbl[18] = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd9,  5'd9,  32'h0000AAAA, 32'h0000AAAA, 1, 1};
        tbl[19] = '{0, 1, 5'd9,  32'h00000001, 4'hF, 1, 5'd4, 5'd4,  5'd9,  32'h0,        32'h0,        0, 0};
        tbl[20] = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd4,  5'd9,  32'h0,        32'h0,        1, 1};
        tbl[21] = '{1, 1, 5'd4,  32'h00000077, 4'hF, 1, 5'd5, 5'd9,  5'd9,  32'h00000001, 32'h00000001, 0, 0};
        tbl[22] = '{0, 0, 5'd0,  32'h0,        4'h0, 0, 5'd0, 5'd4,  5'd5,  32'h0,        32'h0,        0, 0};
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) begin
                m_data[c][i] = 32'h0;
                m_pend[c][i] = 1'b0;
            end
        end
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ws = '0; re = 1'b0; ra = '0; rd_addr = '0;
        #1;
        edge_step();
        edge_step();
        rst = 1'b0;
        #3;
        check_model();
        check("reset dut_a r0 data", rdata_a[31:0], 32'h0);
        check("reset dut_b r0 data", rdata_b[31:0], 32'h0);

        for (int n = 0; n < 23; n++) begin
            rst = tbl[n].rst; we = tbl[n].we; wa = tbl[n].wa; wd = tbl[n].wd; ws = tbl[n].ws;
            re = tbl[n].re; ra = tbl[n].ra; rd_addr = {tbl[n].r1, tbl[n].r0};
            #3;
            check($sformatf("vec%0d dut_a data", n), rdata_a[31:0], tbl[n].ea);
            check($sformatf("vec%0d dut_b data", n), rdata_b[31:0], tbl[n].eb);
            check($sformatf("vec%0d dut_a pend", n), {31'h0, rpend_a[0]}, {31'h0, tbl[n].pa});
            check($sformatf("vec%0d dut_b pend", n), {31'h0, rpend_b[0]}, {31'h0, tbl[n].pb});
            check($sformatf("vec%0d port1 agree", n), rdata_a[63:32],
                  (tbl[n].r1 == tbl[n].r0) ? rdata_a[31:0] : exp_data(0, int'(tbl[n].r1)));
            check_model();
            edge_step();
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(99) < 2);
            we  = ($urandom_range(99) < 60);
            wa  = 5'($urandom_range(31));
            wd  = $urandom;
            ws  = 4'($urandom_range(15));
            re  = ($urandom_range(99) < 35);
            ra  = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
            for (int p = 0; p < 2; p++) begin
                rd_addr[p*AW +: AW] = ($urandom_range(2) == 0) ? wa : 5'($urandom_range(31));
            end
            #3;
            if (!rst) check_model();
            edge_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
